// File: rtl/mlp_pkg.sv
// mlp_pkg: shared constants for the 7-input / 4-hidden / 10-class integer
// classifier. Holds the layer weight and bias tables, the layer sizes and the
// sequencer state type used by mlp_infer_seq.
package mlp_pkg;

   localparam int N_IN  = 7;
   localparam int N_HID = 4;
   localparam int N_OUT = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      L1   = 2'd1,
      L2   = 2'd2,
      DONE = 2'd3
   } state_t;

   // Layer 1: W1[n][i], feature i into hidden neuron n
   localparam logic signed [5:0] W1 [N_HID][N_IN] = '{
      '{ 6'sd12, -6'sd7,  6'sd15,  6'sd3, -6'sd20,  6'sd9,  6'sd31},
      '{ 6'sd2,   6'sd14, -6'sd11, 6'sd8,  6'sd6,  -6'sd30, 6'sd17},
      '{ 6'sd6,   6'sd25,  6'sd13, -6'sd9, 6'sd30,  6'sd11, -6'sd4},
      '{ 6'sd4,  -6'sd15,  6'sd21, 6'sd19, -6'sd6,  6'sd27,  6'sd10}
   };
   localparam logic signed [7:0] B1 [N_HID] = '{8'sd10, 8'sd3, 8'sd8, 8'sd2};

   // Layer 2: W2[k][j], hidden neuron j into class k
   localparam logic signed [5:0] W2 [N_OUT][N_HID] = '{
      '{ 6'sd3,  -6'sd2,  6'sd4,   6'sd1},
      '{-6'sd5,   6'sd20, 6'sd0,   6'sd0},
      '{-6'sd8,   6'sd6,  6'sd7,  -6'sd3},
      '{ 6'sd31,  6'sd31, 6'sd10,  6'sd10},
      '{ 6'sd12, -6'sd9,  6'sd5,   6'sd2},
      '{-6'sd3,  -6'sd3, -6'sd3,  -6'sd3},
      '{ 6'sd7,   6'sd7, -6'sd7,   6'sd7},
      '{ 6'sd0,   6'sd0,  6'sd15, -6'sd15},
      '{-6'sd31,  6'sd5,  6'sd2,   6'sd30},
      '{ 6'sd1,   6'sd1,  6'sd1,   6'sd1}
   };
   localparam logic signed [11:0] B2 [N_OUT] = '{
      12'sd50, 12'sd225, -12'sd20, -12'sd347, 12'sd0,
      12'sd100, -12'sd60, 12'sd90, 12'sd400, 12'sd200
   };

endpackage

// File: rtl/mlp_wrom.sv
// mlp_wrom: combinational weight/bias lookup for both layers.
//   w_layer/w_row/w_col : weight select (layer 0 = W1[n][i], 1 = W2[k][j])
//   b_layer/b_row       : bias select (layer 0 = B1[n], 1 = B2[k])
//   weight              : signed 6-bit weight, 0 when out of range
//   bias                : bias sign-extended to ACC_W, 0 when out of range
module mlp_wrom import mlp_pkg::*; #(
   parameter int ACC_W = 12
) (
   input  logic                    w_layer,
   input  logic [3:0]              w_row,
   input  logic [2:0]              w_col,
   input  logic                    b_layer,
   input  logic [3:0]              b_row,
   output logic signed [5:0]       weight,
   output logic signed [ACC_W-1:0] bias
);

   always_comb begin
      weight = '0;
      if (!w_layer) begin
         if (w_row < 4'(N_HID) && w_col < 3'(N_IN))
            weight = W1[w_row[1:0]][w_col];
      end else begin
         if (w_row < 4'(N_OUT) && w_col < 3'(N_HID))
            weight = W2[w_row][w_col[1:0]];
      end
   end

   always_comb begin
      bias = '0;
      if (!b_layer) begin
         if (b_row < 4'(N_HID))
            bias = ACC_W'(B1[b_row[1:0]]);
      end else begin
         if (b_row < 4'(N_OUT))
            bias = ACC_W'(B2[b_row]);
      end
   end

endmodule

// File: rtl/mlp_infer_seq.sv
// mlp_infer_seq: time-multiplexed inference for the 7/4/10 classifier using one
// shared multiply-accumulate, sequenced through layer 1, layer 2 and argmax.
//   clk, rst       : clock, synchronous active-high reset
//   start, feat    : request handshake; feat latched on acceptance
//   busy           : high while layer 1 or layer 2 is running
//   result_valid   : result held until result_ready
//   result_class   : argmax class 0..9
//   result_score   : winning signed score (ACC_W bits)
module mlp_infer_seq import mlp_pkg::*; #(
   parameter int ACC_W = 12,
   parameter int HID_W = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [6:0]              feat,
   output logic                    busy,
   output logic                    result_valid,
   input  logic                    result_ready,
   output logic [3:0]              result_class,
   output logic signed [ACC_W-1:0] result_score
);

   state_t                  state;
   logic [N_IN-1:0]         feat_q;
   logic [3:0]              row;      // neuron n in L1, class k in L2
   logic [2:0]              col;      // input i in L1, hidden j in L2
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] max_q;
   logic [3:0]              cls_q;
   logic signed [HID_W-1:0] h [N_HID];

   logic                    in_l1, in_l2, last_col, accept, better;
   logic                    b_layer;
   logic [3:0]              b_row;
   logic signed [5:0]       weight;
   logic signed [ACC_W-1:0] bias;
   logic signed [ACC_W-1:0] w_ext, h_ext, term, sum;

   mlp_wrom #(.ACC_W(ACC_W)) u_wrom (
      .w_layer (in_l2),
      .w_row   (row),
      .w_col   (col),
      .b_layer (b_layer),
      .b_row   (b_row),
      .weight  (weight),
      .bias    (bias)
   );

   always_comb begin
      in_l1    = (state == L1);
      in_l2    = (state == L2);
      last_col = in_l1 ? (col == 3'(N_IN - 1)) : (col == 3'(N_HID - 1));
      accept   = start && ((state == IDLE) || (state == DONE && result_ready));
      // Bias fetched is always the one for the next neuron/class: the last L1
      // neuron hands over to class 0 of L2; outside L1/L2 it is neuron 0.
      b_layer  = in_l2 || (in_l1 && row == 4'(N_HID - 1));
      b_row    = '0;
      if (in_l2 || (in_l1 && row != 4'(N_HID - 1)))
         b_row = row + 4'd1;
      w_ext    = ACC_W'(weight);
      h_ext    = ACC_W'(h[col[1:0]]);
      term     = in_l1 ? (feat_q[col] ? w_ext : '0) : w_ext * h_ext;
      sum      = acc + term;
      better   = (row == 4'd0) || (sum > max_q);
   end

   assign busy         = (state == L1) || (state == L2);
   assign result_valid = (state == DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         feat_q       <= '0;
         row          <= '0;
         col          <= '0;
         acc          <= '0;
         max_q        <= '0;
         cls_q        <= '0;
         result_class <= '0;
         result_score <= '0;
         for (int unsigned q = 0; q < N_HID; q++)
            h[q] <= '0;
      end else if (accept) begin
         state  <= L1;
         feat_q <= feat;
         acc    <= bias;
         row    <= '0;
         col    <= '0;
      end else begin
         case (state)
            L1: begin
               if (last_col) begin
                  h[row[1:0]] <= HID_W'(sum);
                  acc         <= bias;
                  col         <= '0;
                  if (row == 4'(N_HID - 1)) begin
                     row   <= '0;
                     state <= L2;
                  end else begin
                     row <= row + 4'd1;
                  end
               end else begin
                  acc <= sum;
                  col <= col + 3'd1;
               end
            end
            L2: begin
               if (last_col) begin
                  acc <= bias;
                  col <= '0;
                  if (better) begin
                     max_q <= sum;
                     cls_q <= row;
                  end
                  if (row == 4'(N_OUT - 1)) begin
                     // Final class may itself win, so publish the post-update winner.
                     row          <= '0;
                     state        <= DONE;
                     result_class <= better ? row : cls_q;
                     result_score <= better ? sum : max_q;
                  end else begin
                     row <= row + 4'd1;
                  end
               end else begin
                  acc <= sum;
                  col <= col + 3'd1;
               end
            end
            DONE: begin
               if (result_ready)
                  state <= IDLE;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mlp_infer_seq.sv
// tb_mlp_infer_seq: self-checking bench for mlp_infer_seq with directed
// scenarios and a randomized regression against a parallel golden model.
module tb_mlp_infer_seq;

   localparam int ACC_W = 12;
   localparam int HID_W = 8;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic                    start = 1'b0;
   logic [6:0]              feat = '0;
   logic                    busy;
   logic                    result_valid;
   logic                    result_ready = 1'b0;
   logic [3:0]              result_class;
   logic signed [ACC_W-1:0] result_score;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Reference network, independent copy of the classifier coefficients
   localparam int TW1 [4][7] = '{
      '{12, -7, 15, 3, -20, 9, 31},
      '{2, 14, -11, 8, 6, -30, 17},
      '{6, 25, 13, -9, 30, 11, -4},
      '{4, -15, 21, 19, -6, 27, 10}
   };
   localparam int TB1 [4] = '{10, 3, 8, 2};
   localparam int TW2 [10][4] = '{
      '{3, -2, 4, 1}, '{-5, 20, 0, 0}, '{-8, 6, 7, -3}, '{31, 31, 10, 10},
      '{12, -9, 5, 2}, '{-3, -3, -3, -3}, '{7, 7, -7, 7}, '{0, 0, 15, -15},
      '{-31, 5, 2, 30}, '{1, 1, 1, 1}
   };
   localparam int TB2 [10] = '{50, 225, -20, -347, 0, 100, -60, 90, 400, 200};
   localparam int EXP_H1 [4] = '{22, 5, 14, 6};

   int m_h [4];

   mlp_infer_seq #(.ACC_W(ACC_W), .HID_W(HID_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .feat         (feat),
      .busy         (busy),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .result_class (result_class),
      .result_score (result_score)
   );

   always #5 clk = ~clk;

   function automatic int wrap(input int v, input int bits);
      int m;
      m = v & ((1 << bits) - 1);
      if (m >= (1 << (bits - 1))) m -= (1 << bits);
      return m;
   endfunction

   // Whole-network evaluation: dot products, wrap, then strict argmax.
   function automatic void model(input logic [6:0] f, output int cls, output int score);
      int s;
      for (int n = 0; n < 4; n++) begin
         s = TB1[n];
         for (int i = 0; i < 7; i++) if (f[i]) s += TW1[n][i];
         m_h[n] = wrap(s, HID_W);
      end
      cls = 0;
      score = 0;
      for (int k = 0; k < 10; k++) begin
         s = TB2[k];
         for (int j = 0; j < 4; j++) s += TW2[k][j] * m_h[j];
         s = wrap(s, ACC_W);
         if (k == 0 || s > score) begin
            score = s;
            cls = k;
         end
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic start_run(input logic [6:0] f);
      start = 1'b1;
      feat  = f;
      tick();
      start = 1'b0;
      feat  = 7'($urandom);
   endtask

   task automatic wait_valid(output int cnt);
      cnt = 0;
      while (result_valid !== 1'b1 && cnt < 300) begin
         tick();
         cnt++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
      n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", result_valid); end
      n_checks++; if (result_class !== 4'd0) begin n_fail++; $display("FAIL reset_class: got %0d expected 0", result_class); end
      n_checks++; if (result_score !== 12'sd0) begin n_fail++; $display("FAIL reset_score: got %0d expected 0", result_score); end
      rst = 1'b0;
      tick();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %0b expected 0", busy); end
   endtask

   task automatic test_zero_feature();
      int cnt;
      start_run(7'h00);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL zero_busy: got %0b expected 1", busy); end
      wait_valid(cnt);
      n_checks++; if (cnt != 68) begin n_fail++; $display("FAIL zero_latency: got %0d expected 68", cnt); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy_done: got %0b expected 0", busy); end
      n_checks++; if (result_class !== 4'd1) begin n_fail++; $display("FAIL zero_class: got %0d expected 1", result_class); end
      n_checks++; if (result_score !== 12'sd235) begin n_fail++; $display("FAIL zero_score: got %0d expected 235", result_score); end
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
      n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL zero_release: got %0b expected 0", result_valid); end
   endtask

   task automatic test_single_feature();
      int cnt;
      int hv;
      start_run(7'h01);
      wait_valid(cnt);
      n_checks++; if (cnt != 68) begin n_fail++; $display("FAIL single_latency: got %0d expected 68", cnt); end
      n_checks++; if (result_class !== 4'd3) begin n_fail++; $display("FAIL single_class: got %0d expected 3", result_class); end
      n_checks++; if (result_score !== 12'sd690) begin n_fail++; $display("FAIL single_score: got %0d expected 690", result_score); end
      for (int j = 0; j < 4; j++) begin
         hv = int'(dut.h[j]);
         n_checks++; if (hv != EXP_H1[j]) begin n_fail++; $display("FAIL single_hidden%0d: got %0d expected %0d", j, hv, EXP_H1[j]); end
      end
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      int cnt, ec, es;
      logic [6:0] f;
      f = 7'($urandom);
      model(f, ec, es);
      start_run(f);
      wait_valid(cnt);
      n_checks++; if (cnt != 68) begin n_fail++; $display("FAIL bp_latency: got %0d expected 68", cnt); end
      for (int c = 0; c < 20; c++) begin
         start = c[0];
         feat  = 7'($urandom);
         tick();
         n_checks++; if (result_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid c%0d: got %0b expected 1", c, result_valid); end
         n_checks++; if (result_class !== 4'(ec)) begin n_fail++; $display("FAIL bp_class c%0d: got %0d expected %0d", c, result_class, ec); end
         n_checks++; if (result_score !== 12'(es)) begin n_fail++; $display("FAIL bp_score c%0d: got %0d expected %0d", c, result_score, es); end
      end
      start = 1'b0;
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
      n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %0b expected 0", result_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_release_busy: got %0b expected 0", busy); end
   endtask

   task automatic test_back_to_back();
      int cnt, last_cyc;
      logic [6:0] cur;
      cur = 7'h00;
      start = 1'b1;
      result_ready = 1'b1;
      feat = cur;
      tick();
      last_cyc = -1;
      for (int r = 0; r < 6; r++) begin
         wait_valid(cnt);
         n_checks++; if (cnt != 68) begin n_fail++; $display("FAIL b2b_latency r%0d: got %0d expected 68", r, cnt); end
         if (last_cyc >= 0) begin
            n_checks++; if (cyc - last_cyc != 69) begin n_fail++; $display("FAIL b2b_period r%0d: got %0d expected 69", r, cyc - last_cyc); end
         end
         last_cyc = cyc;
         n_checks++; if (result_class !== (cur == 7'h00 ? 4'd1 : 4'd3)) begin n_fail++; $display("FAIL b2b_class r%0d: got %0d expected %0d", r, result_class, (cur == 7'h00) ? 1 : 3); end
         n_checks++; if (result_score !== (cur == 7'h00 ? 12'sd235 : 12'sd690)) begin n_fail++; $display("FAIL b2b_score r%0d: got %0d expected %0d", r, result_score, (cur == 7'h00) ? 235 : 690); end
         cur = (cur == 7'h00) ? 7'h01 : 7'h00;
         feat = cur;
         if (r == 5) start = 1'b0;
         tick();
      end
      result_ready = 1'b0;
      n_checks++; if (result_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got valid=%0b busy=%0b expected 0/0", result_valid, busy); end
   endtask

   task automatic test_reset_mid();
      int cnt;
      bit saw_valid;
      start_run(7'($urandom));
      repeat (28) tick();
      repeat (29) tick();
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_pre: got %0b expected 1", busy); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %0b expected 0", busy); end
      n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %0b expected 0", result_valid); end
      n_checks++; if (result_class !== 4'd0) begin n_fail++; $display("FAIL mid_class: got %0d expected 0", result_class); end
      n_checks++; if (result_score !== 12'sd0) begin n_fail++; $display("FAIL mid_score: got %0d expected 0", result_score); end
      saw_valid = 1'b0;
      repeat (80) begin
         tick();
         if (result_valid === 1'b1 || busy === 1'b1) saw_valid = 1'b1;
      end
      n_checks++; if (saw_valid) begin n_fail++; $display("FAIL mid_quiet: got activity=1 expected 0"); end
      start_run(7'h01);
      wait_valid(cnt);
      n_checks++; if (cnt != 68) begin n_fail++; $display("FAIL mid_after_latency: got %0d expected 68", cnt); end
      n_checks++; if (result_class !== 4'd3 || result_score !== 12'sd690) begin n_fail++; $display("FAIL mid_after_result: got %0d/%0d expected 3/690", result_class, result_score); end
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
   endtask

   task automatic test_random();
      int cnt, ec, es;
      logic [6:0] cur;
      cur = 7'($urandom);
      start = 1'b1;
      result_ready = 1'b1;
      feat = cur;
      tick();
      for (int r = 0; r < 1000; r++) begin
         wait_valid(cnt);
         model(cur, ec, es);
         n_checks++; if (cnt != 68) begin n_fail++; $display("FAIL rand_latency r%0d: got %0d expected 68", r, cnt); end
         n_checks++; if (result_class !== 4'(ec)) begin n_fail++; $display("FAIL rand_class r%0d feat=%h: got %0d expected %0d", r, cur, result_class, ec); end
         n_checks++; if (result_score !== 12'(es)) begin n_fail++; $display("FAIL rand_score r%0d feat=%h: got %0d expected %0d", r, cur, result_score, es); end
         cur = 7'($urandom);
         feat = cur;
         if (r == 999) start = 1'b0;
         tick();
      end
      result_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_zero_feature();
      test_single_feature();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mlp_infer_seq.md
# mlp_infer_seq

Time-multiplexed inference controller for the team's 7-input / 4-hidden / 10-class integer classifier. It replaces the fully parallel adder trees with one shared multiply-accumulate datapath, sequenced through layer 1, layer 2 and a running argmax. A start/busy request handshake accepts a feature vector, and a valid/ready handshake returns the class and winning score. It sits between the pin-level feature latch and the output pins of the top-level TT wrapper.

## Interface
Parameters:
- ACC_W, default 12: layer-2 accumulator and score width (signed).
- HID_W, default 8: hidden-neuron width (signed).

Ports:
- clk, in, 1: single clock; all state updates on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- start, in, 1: request a new inference; sampled only when accepted (see Operation).
- feat, in, 7: binary feature vector; latched on acceptance.
- busy, out, 1: high while in L1 or L2.
- result_valid, out, 1: result available; held until accepted.
- result_ready, in, 1: consumer accepts the result.
- result_class, out, 4: argmax index, 0–9.
- result_score, out, ACC_W: winning signed score.

## Operation
- FSM states: IDLE, L1, L2, DONE. Reset state is IDLE.
- Reset values: busy=0, result_valid=0, result_class=0, result_score=0. All counters, hidden registers and max registers reset to 0.
- Acceptance: start is accepted in IDLE, or in DONE when result_ready=1. On acceptance:
  - feat is latched.
  - acc is loaded with the layer-1 bias of neuron 0; n=0, i=0.
  - The state moves to L1.
  - start is ignored in L1 and L2, and in DONE while result_ready=0.
- L1 (28 cycles): each cycle, acc += feat[i] ? W1[n][i] : 0.
  - At i=6: h[n] <= acc + term, truncated to HID_W (two's-complement wrap). acc is then reloaded with the bias of neuron n+1, and i resets to 0.
  - After n=3, acc is loaded with the layer-2 bias of class 0, and the state moves to L2.
- L2 (40 cycles): each cycle, acc += W2[k][j] * h[j]. The product and sum are signed and wrap to ACC_W.
  - At j=3: score = acc + term.
  - If k=0, or score > max (signed, strict), then max <= score and cls <= k.
  - acc is then reloaded with the bias of class k+1.
  - After k=9, the state moves to DONE.
- Ties: the lowest class index wins, because the comparison is strict.
- DONE: result_valid=1. result_class and result_score are driven from cls and max and stay stable until the handshake completes.
  - With result_ready=1 and start=0, the state moves to IDLE.
  - With result_ready=1 and start=1, the state moves directly to L1.
- Reset mid-operation (any state): return to IDLE. The partial result is discarded and no result_valid pulse is produced.

## Timing
- Let E0 be the edge that accepts start. L1 spans E0..E28 and L2 spans E28..E68.
- result_valid rises after E68, so latency is 68 cycles.
- busy is high after E0 through E68.
- Back-to-back operation, with result_ready held at 1 and start held at 1, gives one result every 69 cycles.
- feat changes after E0 have no effect on the running inference.
- result_class and result_score change only on the L2→DONE transition, or on reset.

## Structure
- Package mlp_pkg holds:
  - W1 (4×7 signed 6-bit) and B1 (4 entries).
  - W2 (10×4 signed 6-bit) and B2 (10 entries, signed ACC_W).
  - N_IN=7, N_HID=4, N_OUT=10.
  - The FSM state enum.
- Sub-module mlp_wrom: a combinational weight/bias lookup indexed by (layer, n/k, i/j). Keeping it separate leaves the FSM, counters and MAC in mlp_infer_seq.

## Test plan
- Zero features: feat=7'h00, start pulse → result_valid exactly 68 cycles after acceptance; result_class=1, result_score=235.
- Single feature: feat=7'h01 → result_class=3, result_score=690. Intermediate hidden values h = {22, 5, 14, 6}.
- Backpressure: hold result_ready=0 for 20 cycles in DONE → outputs stable; start pulses are ignored; completion after result_ready rises.
- Back-to-back: start and result_ready tied high, alternating feat 7'h00 / 7'h01 → results 1/235 and 3/690 every 69 cycles.
- Reset mid-run: assert rst at cycle 30 of L2 → the next cycle shows busy=0, result_valid=0 and outputs 0. A following start gives the correct result.
- Random regression: 1000 random feat vectors checked against the parallel golden model, with the lowest-index tie rule and ACC_W wrap applied.
